// File: rtl/mmio_periph_hub_pkg.sv
// rtl/mmio_periph_hub_pkg.sv - shared register offsets, timer control bits and hex-to-segment table
package mmio_hub_pkg;

  // Word offsets, i.e. addr[7:2]
  localparam logic [5:0] OFF_GPIO_OUT = 6'h00;
  localparam logic [5:0] OFF_GPIO_IN  = 6'h01;
  localparam logic [5:0] OFF_SEG_VAL  = 6'h02;
  localparam logic [5:0] OFF_TCNT     = 6'h03;
  localparam logic [5:0] OFF_TCMP     = 6'h04;
  localparam logic [5:0] OFF_TCTRL    = 6'h05;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_PEND = 2;

  // Segments g..a, active-low
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/mmio_periph_hub_if.sv
// rtl/mmio_periph_hub_if.sv - data-memory port bundle between the core (master) and the hub (slave)
interface mmio_periph_hub_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  wr_req_i;
  logic [DATA_W/8-1:0]   wr_sel_i;
  logic [ADDR_W-1:0]     wr_addr_i;
  logic [DATA_W-1:0]     wr_data_i;
  logic                  rd_req_i;
  logic [ADDR_W-1:0]     rd_addr_i;
  logic [DATA_W-1:0]     rd_data_o;
  logic                  rd_hit_o;

  modport master (
    output wr_req_i, wr_sel_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i,
    input  rd_data_o, rd_hit_o
  );

  modport slave (
    input  wr_req_i, wr_sel_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i,
    output rd_data_o, rd_hit_o
  );
endinterface

// File: rtl/mmio_periph_hub_seg_scan_mux.sv
// rtl/mmio_periph_hub_seg_scan_mux.sv - digit scanner and hex decode for the seven-segment display
// Optional leading-zero blanking: MMIO_HUB_SEG_LZB_EN
module seg_scan_mux
  import mmio_hub_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] seg_val_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [PRE_W-1:0]      r_pre;
  logic [IDX_W-1:0]      r_idx;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  w_tc;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [3:0]            w_nib;
  logic                  w_blank;

  assign w_tc = (r_pre == PRE_W'(SCAN_DIV - 1));

  // Segments and anodes are both registered from the next index so they switch on the same edge
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_tc)
      w_idx_nxt = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    w_nib   = seg_val_i[{w_idx_nxt, 2'b00} +: 4];
    w_blank = 1'b0;
`ifdef MMIO_HUB_SEG_LZB_EN
    w_blank = (w_idx_nxt != '0) && ((seg_val_i >> {w_idx_nxt, 2'b00}) == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_idx <= '0;
      r_seg <= 7'b1000000;
      r_an  <= ~NUM_DIGITS'(1);
    end else begin
      r_pre <= w_tc ? '0 : r_pre + PRE_W'(1);
      r_idx <= w_idx_nxt;
      r_seg <= w_blank ? 7'h7F : HEX_SEG[w_nib];
      r_an  <= ~(NUM_DIGITS'(1) << w_idx_nxt);
    end
  end

  assign seg_o = r_seg;
  assign an_o  = r_an;

endmodule

// File: rtl/mmio_periph_hub.sv
// rtl/mmio_periph_hub.sv - memory-mapped hub: GPIO, scanned seven-segment display, compare timer with irq
// Optional leading-zero blanking: MMIO_HUB_SEG_LZB_EN (implemented in seg_scan_mux)
module mmio_periph_hub
  import mmio_hub_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h4000_0000,
  parameter int                GPIO_W     = 8,
  parameter int                NUM_DIGITS = 4,
  parameter int                SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_periph_hub_if.slave      bus,
  input  logic [GPIO_W-1:0]     gpio_i,
  output logic [GPIO_W-1:0]     gpio_o,
  output logic [6:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  timer_irq_o
);

  localparam int NB = DATA_W / 8;

  logic [GPIO_W-1:0] r_gpio_out, r_gpio_s1, r_gpio_s2;
  logic [DATA_W-1:0] r_seg_val, r_tcnt, r_tcmp, r_rd_data;
  logic              r_en, r_auto, r_pend, r_rd_hit;

  logic              w_wr_hit, w_rd_hit, w_match, w_w1c, w_pend_nxt, w_unused;
  logic [5:0]        w_wr_off;
  logic [DATA_W-1:0] w_wmask, w_tcnt_nxt, w_rd_val;

  assign w_wr_hit = bus.wr_req_i && (bus.wr_addr_i[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
  assign w_rd_hit = bus.rd_req_i && (bus.rd_addr_i[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
  assign w_wr_off = bus.wr_addr_i[7:2];
  assign w_unused = ^{bus.wr_addr_i[1:0], bus.rd_addr_i[1:0]};

  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < NB; b++)
      w_wmask[8*b +: 8] = {8{bus.wr_sel_i[b]}};
  end

  // Timer: a software count write overrides increment/reload; a hardware match overrides W1C
  always_comb begin
    w_match    = r_en && (r_tcnt == r_tcmp);
    w_tcnt_nxt = r_tcnt;
    if (r_en)
      w_tcnt_nxt = (w_match && r_auto) ? '0 : r_tcnt + DATA_W'(1);
    if (w_wr_hit && (w_wr_off == OFF_TCNT))
      w_tcnt_nxt = (r_tcnt & ~w_wmask) | (bus.wr_data_i & w_wmask);
    w_w1c      = w_wr_hit && (w_wr_off == OFF_TCTRL) && bus.wr_sel_i[0] && bus.wr_data_i[CTRL_PEND];
    w_pend_nxt = w_match ? 1'b1 : (w_w1c ? 1'b0 : r_pend);
  end

  always_comb begin
    w_rd_val = '0;
    case (bus.rd_addr_i[7:2])
      OFF_GPIO_OUT: w_rd_val[GPIO_W-1:0] = r_gpio_out;
      OFF_GPIO_IN:  w_rd_val[GPIO_W-1:0] = r_gpio_s2;
      OFF_SEG_VAL:  w_rd_val = r_seg_val;
      OFF_TCNT:     w_rd_val = r_tcnt;
      OFF_TCMP:     w_rd_val = r_tcmp;
      OFF_TCTRL: begin
        w_rd_val[CTRL_EN]   = r_en;
        w_rd_val[CTRL_AUTO] = r_auto;
        w_rd_val[CTRL_PEND] = r_pend;
      end
      default:      w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gpio_out <= '0;
      r_gpio_s1  <= '0;
      r_gpio_s2  <= '0;
      r_seg_val  <= '0;
      r_tcnt     <= '0;
      r_tcmp     <= '0;
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      r_pend     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_hit   <= 1'b0;
    end else begin
      r_gpio_s1 <= gpio_i;
      r_gpio_s2 <= r_gpio_s1;
      r_tcnt    <= w_tcnt_nxt;
      r_pend    <= w_pend_nxt;
      r_rd_hit  <= w_rd_hit;
      r_rd_data <= w_rd_hit ? w_rd_val : '0;
      if (w_wr_hit) begin
        case (w_wr_off)
          OFF_GPIO_OUT: r_gpio_out <= (r_gpio_out & ~w_wmask[GPIO_W-1:0])
                                    | (bus.wr_data_i[GPIO_W-1:0] & w_wmask[GPIO_W-1:0]);
          OFF_SEG_VAL:  r_seg_val  <= (r_seg_val & ~w_wmask) | (bus.wr_data_i & w_wmask);
          OFF_TCMP:     r_tcmp     <= (r_tcmp & ~w_wmask) | (bus.wr_data_i & w_wmask);
          OFF_TCTRL: begin
            if (bus.wr_sel_i[0]) begin
              r_en   <= bus.wr_data_i[CTRL_EN];
              r_auto <= bus.wr_data_i[CTRL_AUTO];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rd_data_o = r_rd_data;
  assign bus.rd_hit_o  = r_rd_hit;
  assign gpio_o        = r_gpio_out;
  assign timer_irq_o   = r_pend;

  seg_scan_mux #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .seg_val_i (r_seg_val[4*NUM_DIGITS-1:0]),
    .seg_o     (seg_o),
    .an_o      (an_o)
  );

endmodule

// File: tb/tb_mmio_periph_hub.sv
// tb/tb_mmio_periph_hub.sv - self-checking bench for mmio_periph_hub (honours MMIO_HUB_SEG_LZB_EN)
module tb_mmio_periph_hub;

  localparam int SCAN = 4;
  localparam logic [31:0] A_GOUT = 32'h4000_0000;
  localparam logic [31:0] A_GIN  = 32'h4000_0004;
  localparam logic [31:0] A_SEG  = 32'h4000_0008;
  localparam logic [31:0] A_CNT  = 32'h4000_000C;
  localparam logic [31:0] A_CMP  = 32'h4000_0010;
  localparam logic [31:0] A_CTRL = 32'h4000_0014;
  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    bit          wr;
    logic [31:0] waddr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    bit          rd;
    logic [31:0] raddr;
    bit          exp_hit;
    logic [31:0] exp_rd;
    logic [7:0]  exp_gpio;
  } vec_t;

  logic       clk, rst;
  logic [7:0] gpio_i, gpio_o;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  logic       timer_irq_o;
  int         n_chk, n_fail, n_edges;
  vec_t       vt [17];
  logic [31:0] mdl [6];

  mmio_periph_hub_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mmio_periph_hub #(.SCAN_DIV(SCAN)) dut (
    .clk(clk), .rst(rst), .bus(bus), .gpio_i(gpio_i), .gpio_o(gpio_o),
    .seg_o(seg_o), .an_o(an_o), .timer_irq_o(timer_irq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst)
    if (!rst) n_edges <= 0;
    else      n_edges <= n_edges + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bus_cycle(input bit wr, input logic [31:0] waddr, input logic [3:0] sel,
                           input logic [31:0] wdata, input bit rd, input logic [31:0] raddr);
    bus.wr_req_i = wr; bus.wr_addr_i = waddr; bus.wr_sel_i = sel; bus.wr_data_i = wdata;
    bus.rd_req_i = rd; bus.rd_addr_i = raddr;
    @(posedge clk);
    @(negedge clk);
    bus.wr_req_i = 1'b0;
    bus.rd_req_i = 1'b0;
  endtask

  task automatic idle();
    bus_cycle(0, 32'h0, 4'h0, 32'h0, 0, 32'h0);
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] val, input int idx);
    logic [15:0] hi;
    hi = val >> (4 * idx);
`ifdef MMIO_HUB_SEG_LZB_EN
    if (idx != 0 && hi == 16'h0) return 7'h7F;
`endif
    return HEX[hi[3:0]];
  endfunction

  // Digit index follows directly from the number of clock edges since reset release
  task automatic check_scan(input logic [15:0] val, input int ncyc);
    logic [3:0] one, ea;
    int idx;
    one = 4'b0001;
    for (int c = 0; c < ncyc; c++) begin
      idle();
      idx = (n_edges / SCAN) % 4;
      ea  = ~(one << idx);
      chk("scan_an", {28'h0, an_o}, {28'h0, ea});
      chk("scan_seg", {25'h0, seg_o}, {25'h0, exp_seg(val, idx)});
    end
  endtask

  task automatic pick_addr(output logic [31:0] a, output int off, output bit outside);
    int p;
    p = $urandom % 8;
    outside = 0;
    case (p)
      0: off = 0;
      1: off = 2;
      2: off = 3;
      3: off = 4;
      4: off = 5;
      5: off = 1;
      6: off = $urandom_range(6, 63);
      default: begin off = 0; outside = 1; end
    endcase
    a = outside ? (32'h8000_0000 | $urandom) : (32'h4000_0000 | (32'(off) << 2) | ($urandom % 4));
  endtask

  initial begin
    logic [31:0] wa, ra, wd, er;
    logic [3:0]  sl;
    int          wo, ro;
    bit          wout, rout, wr, rd, found;

    n_chk = 0; n_fail = 0;
    rst = 1'b0; gpio_i = 8'h00;
    bus.wr_req_i = 0; bus.wr_sel_i = 0; bus.wr_addr_i = 0; bus.wr_data_i = 0;
    bus.rd_req_i = 0; bus.rd_addr_i = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    chk("rst_an", {28'h0, an_o}, 32'hE);
    chk("rst_seg", {25'h0, seg_o}, 32'h40);
    chk("rst_gpio", {24'h0, gpio_o}, 32'h0);
    chk("rst_irq", {31'h0, timer_irq_o}, 32'h0);
    chk("rst_hit", {31'h0, bus.rd_hit_o}, 32'h0);
    chk("rst_rdata", bus.rd_data_o, 32'h0);

    for (int i = 0; i < 6; i++)
      vt[i] = '{0, 32'h0, 4'h0, 32'h0, 1, 32'h4000_0000 + 32'(4 * i), 1, 32'h0, 8'h00};
    vt[6]  = '{0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 0, 32'h0, 8'h00};
    vt[7]  = '{1, A_GOUT, 4'b0001, 32'h0000_00A5, 0, 32'h0, 0, 32'h0, 8'hA5};
    vt[8]  = '{1, A_GOUT, 4'b0010, 32'h0000_FF00, 0, 32'h0, 0, 32'h0, 8'hA5};
    vt[9]  = '{0, 32'h0, 4'h0, 32'h0, 1, 32'h4000_0003, 1, 32'h0000_00A5, 8'hA5};
    vt[10] = '{0, 32'h0, 4'h0, 32'h0, 1, 32'h3FFF_FF00, 0, 32'h0, 8'hA5};
    vt[11] = '{0, 32'h0, 4'h0, 32'h0, 1, 32'h4000_0100, 0, 32'h0, 8'hA5};
    vt[12] = '{0, 32'h0, 4'h0, 32'h0, 1, 32'h4000_0040, 1, 32'h0, 8'hA5};
    vt[13] = '{1, 32'h4000_0040, 4'hF, 32'hFFFF_FFFF, 1, 32'h4000_0040, 1, 32'h0, 8'hA5};
    vt[14] = '{1, A_GOUT, 4'hF, 32'h1234_5678, 1, A_GOUT, 1, 32'h0000_00A5, 8'h78};
    vt[15] = '{1, A_GOUT, 4'b0001, 32'h0000_00A5, 1, A_GOUT, 1, 32'h0000_0078, 8'hA5};
    vt[16] = '{1, A_GIN, 4'hF, 32'hFFFF_FFFF, 1, A_GIN, 1, 32'h0, 8'hA5};

    for (int i = 0; i < 17; i++) begin
      bus_cycle(vt[i].wr, vt[i].waddr, vt[i].sel, vt[i].wdata, vt[i].rd, vt[i].raddr);
      chk($sformatf("vec%0d_hit", i), {31'h0, bus.rd_hit_o}, {31'h0, vt[i].exp_hit});
      chk($sformatf("vec%0d_rdata", i), bus.rd_data_o, vt[i].exp_rd);
      chk($sformatf("vec%0d_gpio", i), {24'h0, gpio_o}, {24'h0, vt[i].exp_gpio});
    end

    gpio_i = 8'h3C;
    for (int k = 1; k <= 3; k++) begin
      bus_cycle(0, 32'h0, 4'h0, 32'h0, 1, A_GIN);
      chk($sformatf("gpio_in_edge%0d", k), bus.rd_data_o, (k >= 3) ? 32'h3C : 32'h0);
    end

    mdl[0] = 32'hA5; mdl[1] = 32'h3C; mdl[2] = 0; mdl[3] = 0; mdl[4] = 0; mdl[5] = 0;
    for (int n = 0; n < 200; n++) begin
      wr = $urandom % 2; rd = $urandom % 2;
      pick_addr(wa, wo, wout);
      pick_addr(ra, ro, rout);
      wd = $urandom; sl = 4'($urandom % 16);
      if (!wout && wo == 5) wd[0] = 1'b0;
      er = (rd && !rout && ro <= 5) ? mdl[ro] : 32'h0;
      bus_cycle(wr, wa, sl, wd, rd, ra);
      chk("rand_hit", {31'h0, bus.rd_hit_o}, {31'h0, rd && !rout});
      chk("rand_rdata", bus.rd_data_o, er);
      if (wr && !wout) begin
        if (wo == 5) begin
          if (sl[0]) mdl[5] = {30'h0, wd[1:0]};
        end else if (wo != 1 && wo <= 4) begin
          for (int b = 0; b < 4; b++)
            if (sl[b]) mdl[wo][8*b +: 8] = wd[8*b +: 8];
          if (wo == 0) mdl[0] = mdl[0] & 32'hFF;
        end
      end
      chk("rand_gpio", {24'h0, gpio_o}, mdl[0] & 32'hFF);
    end

    bus_cycle(1, A_SEG, 4'hF, 32'h0000_12AF, 0, 32'h0);
    idle();
    check_scan(16'h12AF, 20);
    bus_cycle(1, A_SEG, 4'hF, 32'h0000_000F, 0, 32'h0);
    idle();
    check_scan(16'h000F, 16);

    bus_cycle(1, A_CNT, 4'hF, 32'h0, 0, 32'h0);
    bus_cycle(1, A_CMP, 4'hF, 32'h5, 0, 32'h0);
    bus_cycle(1, A_CTRL, 4'b0001, 32'h3, 0, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      bus_cycle(0, 32'h0, 4'h0, 32'h0, 1, A_CNT);
      chk($sformatf("tmr_cnt%0d", k), bus.rd_data_o, (k <= 6) ? 32'(k - 1) : 32'h0);
      chk($sformatf("tmr_irq%0d", k), {31'h0, timer_irq_o}, (k >= 6) ? 32'h1 : 32'h0);
    end
    bus_cycle(1, A_CTRL, 4'b0001, 32'h7, 0, 32'h0);
    chk("w1c_clear", {31'h0, timer_irq_o}, 32'h0);
    repeat (3) idle();
    bus_cycle(1, A_CTRL, 4'b0001, 32'h7, 0, 32'h0);
    chk("w1c_vs_match", {31'h0, timer_irq_o}, 32'h1);
    bus_cycle(1, A_CTRL, 4'b0010, 32'h4, 1, A_CTRL);
    chk("w1c_no_byte0", {31'h0, timer_irq_o}, 32'h1);
    chk("ctrl_read", bus.rd_data_o, 32'h7);

    bus_cycle(1, A_CTRL, 4'b0001, 32'h4, 0, 32'h0);
    bus_cycle(1, A_CNT, 4'hF, 32'h0, 0, 32'h0);
    bus_cycle(1, A_CMP, 4'hF, 32'd100, 0, 32'h0);
    bus_cycle(1, A_CTRL, 4'b0001, 32'h1, 0, 32'h0);
    bus_cycle(1, A_GOUT, 4'b0001, 32'hFF, 0, 32'h0);
    idle();
    bus_cycle(0, 32'h0, 4'h0, 32'h0, 1, A_CNT);
    chk("midcnt_val", bus.rd_data_o, 32'h2);
    rst = 1'b0;
    #1;
    chk("rstc_gpio", {24'h0, gpio_o}, 32'h0);
    chk("rstc_hit", {31'h0, bus.rd_hit_o}, 32'h0);
    chk("rstc_rdata", bus.rd_data_o, 32'h0);
    chk("rstc_irq", {31'h0, timer_irq_o}, 32'h0);
    chk("rstc_an", {28'h0, an_o}, 32'hE);
    chk("rstc_seg", {25'h0, seg_o}, 32'h40);
    @(negedge clk);
    rst = 1'b1;
    bus_cycle(0, 32'h0, 4'h0, 32'h0, 1, A_CNT);
    chk("post_rst_cnt", bus.rd_data_o, 32'h0);
    bus_cycle(1, A_CTRL, 4'b0001, 32'h1, 0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      bus_cycle(0, 32'h0, 4'h0, 32'h0, 1, A_CNT);
      chk($sformatf("resume_cnt%0d", k), bus.rd_data_o, 32'(k - 1));
    end

    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (an_o == 4'b1011) found = 1;
      else idle();
    end
    chk("scan_idx2_reached", {31'h0, found}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rsts_an", {28'h0, an_o}, 32'hE);
    chk("rsts_seg", {25'h0, seg_o}, 32'h40);
    chk("rsts_irq", {31'h0, timer_irq_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    check_scan(16'h0000, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_periph_hub.md
Name: mmio_periph_hub

Overview:
- Parametrised memory-mapped peripheral block on the core's data-memory port, alongside `ram`.
- Replaces ad-hoc direct taps of write data with decoded, byte-enabled registers.
- Provides GPIO out/in, a scanned N-digit seven-segment display and a compare timer with interrupt.
- Reads use the same 1-cycle latency as `ram`, so the SoC muxes read data on the registered hit flag.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width; must be a multiple of 8.
- BASE_ADDR, 32'h4000_0000: window base; the window is 256 bytes (bits [7:0] ignored for the hit).
- GPIO_W, 8: GPIO width, 1..DATA_W.
- NUM_DIGITS, 4: display digits, 1..DATA_W/4.
- SCAN_DIV, 50000: clock cycles per digit slot, ≥2.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- wr_req_i, in, 1: write strobe.
- wr_sel_i, in, DATA_W/8: byte enables.
- wr_addr_i, in, ADDR_W: write address.
- wr_data_i, in, DATA_W: write data.
- rd_req_i, in, 1: read strobe.
- rd_addr_i, in, ADDR_W: read address.
- rd_data_o, out, DATA_W: registered read data.
- rd_hit_o, out, 1: registered; high when rd_data_o is valid from this block.
- gpio_i, in, GPIO_W: asynchronous inputs.
- gpio_o, out, GPIO_W: GPIO outputs.
- seg_o, out, 7: segments g..a, active-low.
- an_o, out, NUM_DIGITS: digit enables, active-low one-hot.
- timer_irq_o, out, 1: level interrupt, equals the pending bit.

Behaviour:
- Hit: addr[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]. Register offset = addr[7:2]; addr[1:0] is ignored.
- Register map:
  - 0x00 GPIO_OUT, RW.
  - 0x04 GPIO_IN, RO; 2-flop synchronised.
  - 0x08 SEG_VAL, RW; nibble k feeds digit k.
  - 0x0C TIMER_CNT, RW.
  - 0x10 TIMER_CMP, RW.
  - 0x14 TIMER_CTRL: bit0 EN (RW), bit1 AUTO_RELOAD (RW), bit2 PEND (R, write-1-to-clear).
  - All other in-window offsets read 0; writes to them are ignored.
- Writes:
  - Take effect on the clk edge where wr_req_i && hit.
  - Only bytes with wr_sel_i[b]=1 update.
  - The PEND clear requires byte 0 to be enabled.
- Reads:
  - rd_req_i && hit at edge N → rd_data_o/rd_hit_o valid after edge N.
  - Without a hit: rd_hit_o=0 and rd_data_o=0.
  - Unused upper bits read 0.
- Same-cycle read and write to the same register: the read returns the old value.
- Timer:
  - When EN=1, TIMER_CNT increments every cycle and wraps at 2^DATA_W.
  - On a cycle where TIMER_CNT==TIMER_CMP and EN=1: PEND←1. If AUTO_RELOAD=1, the next value is 0; otherwise counting continues.
  - A software write to TIMER_CNT beats the increment or reload in the same cycle.
  - A hardware PEND set beats a simultaneous W1C.
  - When EN=0, the count holds and no match is evaluated.
- Scanner:
  - Prescaler counts 0..SCAN_DIV-1. On terminal count, the digit index advances modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
  - an_o = ~(1<<idx).
  - seg_o = active-low hex decode of SEG_VAL[4*idx+3:4*idx] (0→7'b1000000, F→7'b0001110), registered to align with an_o.
- Reset (rst=0, asynchronous) clears all registers, prescaler, index and synchroniser flops. Output values in reset:
  - rd_data_o=0, rd_hit_o=0, gpio_o=0, timer_irq_o=0.
  - an_o=~1 (digit 0 on).
  - seg_o=7'b1000000.
- Reset asserted mid-scan or mid-count returns everything to these values immediately; there is no partial state.

Optional Feature:
- Macro MMIO_HUB_SEG_LZB_EN.
- Defined: leading-zero blanking. A digit whose nibble and all higher-index nibbles are 0 drives seg_o=7'h7F while its an_o is active. Digit 0 is never blanked.
- Undefined: every digit shows its hex value, including leading zeros.

Decomposition:
- Package mmio_hub_pkg holds:
  - offset constants: OFF_GPIO_OUT, OFF_GPIO_IN, OFF_SEG_VAL, OFF_TCNT, OFF_TCMP, OFF_TCTRL;
  - TIMER_CTRL bit indices;
  - the 16-entry hex-to-segment constant table.
- One sub-module, seg_scan_mux: prescaler, digit index, nibble select, decode and blanking. Its inputs are SEG_VAL; its outputs are seg_o and an_o.

Test Plan:
- Post-reset, read all six offsets → all 0. Outputs: an_o=4'b1110, seg_o=7'b1000000, rd_hit_o pulses one cycle after each read.
- Write 0x0000_00A5 to 0x00 with wr_sel=4'b0001, then 0xFF00 with 4'b0010 → gpio_o=8'hA5. A read of an address outside the window → rd_hit_o=0.
- Drive gpio_i=8'h3C → GPIO_IN reads 0x3C no earlier than the third edge after the change.
- SCAN_DIV=4: write SEG_VAL=0x0000_12AF → an_o walks 1110,1101,1011,0111 every 4 cycles. seg_o shows F, A, 2, 1. With the macro and SEG_VAL=0x0000_000F → digits 1-3 give 7'h7F.
- CMP=5, CTRL=0x3 → PEND sets on the match cycle and timer_irq_o=1; TIMER_CNT reads 0 the next cycle. A W1C in the same cycle as a later match leaves PEND=1.
- Assert rst mid-count (CNT=3) and mid-scan (idx=2) → immediate return to the reset values; counting resumes from 0 after release.
